// File: rtl/avst_mult_pkg.sv
// avst_mult_pkg: shared FSM type, constants and sign helper for the Avalon-ST multiplier slave.
package avst_mult_pkg;
   typedef enum logic [1:0] {IDLE, CALC, PUSH} state_t;
   localparam int STATS_W = 32;
   localparam int MAG_W = 64;
   // Conditional two's-complement negate; callers truncate the result to their own width.
   function automatic logic [MAG_W-1:0] cond_neg(input logic [MAG_W-1:0] v, input logic neg);
      return neg ? -v : v;
   endfunction
endpackage

// File: rtl/avst_mult_fifo.sv
// avst_mult_fifo: synchronous show-ahead FIFO; dout reads zero while empty.
module avst_mult_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         din,
   output logic [WIDTH-1:0]         dout,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, rd_q;
   logic [AW:0]      count_q;
   logic             pop_ok;
   assign pop_ok = pop && count_q != '0;
   assign dout   = count_q != '0 ? mem_q[rd_q] : '0;
   assign count  = count_q;
   always_ff @(posedge clk)
      if (push) mem_q[wr_q] <= din;
   always_ff @(posedge clk)
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_q + AW'(push);
         rd_q    <= rd_q + AW'(pop_ok);
         count_q <= count_q + (AW+1)'(push) - (AW+1)'(pop_ok);
      end
endmodule

// File: rtl/avalon_st_mult_slave.sv
// avalon_st_mult_slave: Avalon-ST shift-add multiplier with a show-ahead result FIFO.
// Define AVST_MULT_STATS_EN to add saturating ops_count/stall_count outputs.
module avalon_st_mult_slave
   import avst_mult_pkg::*;
#(
   parameter int SZ         = 32,
   parameter int FIFO_DEPTH = 4,
   parameter int SIGNED     = 0
) (
   input  logic                          clk,
   input  logic                          _rst,
   input  logic                          snk_valid,
   output logic                          snk_ready,
   input  logic [2*SZ-1:0]               snk_data,
   output logic                          src_valid,
   input  logic                          src_ready,
   output logic [2*SZ-1:0]               src_data,
   output logic                          busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
`ifdef AVST_MULT_STATS_EN
   ,
   output logic [STATS_W-1:0]            ops_count,
   output logic [STATS_W-1:0]            stall_count
`endif
);
   localparam int CW = $clog2(SZ);
   localparam int FW = $clog2(FIFO_DEPTH) + 1;
   state_t           state_q;
   logic [2*SZ-1:0]  mcand_q, acc_q, acc_d, result;
   logic [SZ-1:0]    mplier_q, a, b, a_mag, b_mag;
   logic [CW-1:0]    cnt_q;
   logic             neg_q, sgn, accept;
   assign sgn       = SIGNED != 0;
   assign a         = snk_data[2*SZ-1:SZ];
   assign b         = snk_data[SZ-1:0];
   assign a_mag     = SZ'(cond_neg(MAG_W'(a), sgn && a[SZ-1]));
   assign b_mag     = SZ'(cond_neg(MAG_W'(b), sgn && b[SZ-1]));
   assign acc_d     = acc_q + (mplier_q[0] ? mcand_q : '0);
   assign result    = (2*SZ)'(cond_neg(MAG_W'(acc_q), neg_q));
   // Gating with reset keeps snk_ready low through the whole reset pulse.
   assign snk_ready = !_rst && state_q == IDLE && fifo_count != FW'(FIFO_DEPTH);
   assign accept    = snk_valid && snk_ready;
   assign busy      = state_q != IDLE;
   assign src_valid = fifo_count != '0;
   always_ff @(posedge clk)
      if (_rst) begin
         state_q  <= IDLE;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         cnt_q    <= '0;
         neg_q    <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (accept) begin
               state_q  <= CALC;
               mcand_q  <= {SZ'(0), a_mag};
               mplier_q <= b_mag;
               acc_q    <= '0;
               cnt_q    <= '0;
               neg_q    <= sgn && (a[SZ-1] ^ b[SZ-1]);
            end
            CALC: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 1'b1;
               if (cnt_q == CW'(SZ-1)) state_q <= PUSH;
            end
            PUSH:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   avst_mult_fifo #(.WIDTH(2*SZ), .DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (_rst),
      .push  (state_q == PUSH),
      .pop   (src_ready),
      .din   (result),
      .dout  (src_data),
      .count (fifo_count)
   );
`ifdef AVST_MULT_STATS_EN
   always_ff @(posedge clk)
      if (_rst) begin
         ops_count   <= '0;
         stall_count <= '0;
      end else begin
         if (src_valid && src_ready && ops_count != '1) ops_count <= ops_count + 1'b1;
         if (src_valid && !src_ready && stall_count != '1) stall_count <= stall_count + 1'b1;
      end
`endif
endmodule

// File: tb/tb_avalon_st_mult_slave.sv
// tb_avalon_st_mult_slave: scoreboard bench for an unsigned and a signed 8-bit instance.
module tb_avalon_st_mult_slave;
   localparam int SZ = 8;
   localparam int D  = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic        u_snk_valid = 1'b0, u_snk_ready, u_src_valid, u_src_ready = 1'b0, u_busy;
   logic [15:0] u_snk_data = '0, u_src_data;
   logic [2:0]  u_cnt;
   logic        s_snk_valid = 1'b0, s_snk_ready, s_src_valid, s_src_ready = 1'b0, s_busy;
   logic [15:0] s_snk_data = '0, s_src_data;
   logic [2:0]  s_cnt;
`ifdef AVST_MULT_STATS_EN
   logic [31:0] u_ops, u_stall, s_ops, s_stall;
`endif
   avalon_st_mult_slave #(.SZ(SZ), .FIFO_DEPTH(D), .SIGNED(0)) u_dut (
      .clk(clk), ._rst(rst),
      .snk_valid(u_snk_valid), .snk_ready(u_snk_ready), .snk_data(u_snk_data),
      .src_valid(u_src_valid), .src_ready(u_src_ready), .src_data(u_src_data),
      .busy(u_busy), .fifo_count(u_cnt)
`ifdef AVST_MULT_STATS_EN
      , .ops_count(u_ops), .stall_count(u_stall)
`endif
   );
   avalon_st_mult_slave #(.SZ(SZ), .FIFO_DEPTH(D), .SIGNED(1)) s_dut (
      .clk(clk), ._rst(rst),
      .snk_valid(s_snk_valid), .snk_ready(s_snk_ready), .snk_data(s_snk_data),
      .src_valid(s_src_valid), .src_ready(s_src_ready), .src_data(s_src_data),
      .busy(s_busy), .fifo_count(s_cnt)
`ifdef AVST_MULT_STATS_EN
      , .ops_count(s_ops), .stall_count(s_stall)
`endif
   );
   int total = 0;
   int bad = 0;
   logic [15:0] q_u[$];
   logic [15:0] q_s[$];
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   function automatic logic [15:0] model(input bit sgn, input logic [7:0] a, input logic [7:0] b);
      logic signed [15:0] sa, sb;
      logic [15:0] ua, ub;
      sa = $signed(a);
      sb = $signed(b);
      ua = {8'h00, a};
      ub = {8'h00, b};
      return sgn ? 16'(sa * sb) : 16'(ua * ub);
   endfunction
   always @(negedge clk) begin
      if (!rst && u_src_valid && u_src_ready) begin
         if (q_u.size() == 0) check("u_unexpected", 64'(q_u.size()), 1);
         else check("u_data", u_src_data, q_u.pop_front());
      end
      if (!rst && s_src_valid && s_src_ready) begin
         if (q_s.size() == 0) check("s_unexpected", 64'(q_s.size()), 1);
         else check("s_data", s_src_data, q_s.pop_front());
      end
   end
   task automatic send(input bit sgn, input logic [7:0] a, input logic [7:0] b, input bit track);
      bit ok = 1'b0;
      if (sgn) begin s_snk_valid = 1'b1; s_snk_data = {a, b}; end
      else begin u_snk_valid = 1'b1; u_snk_data = {a, b}; end
      for (int i = 0; i < 300 && !ok; i++) begin
         @(negedge clk);
         ok = sgn ? s_snk_ready : u_snk_ready;
         @(posedge clk);
         #1;
      end
      if (ok && track) begin
         if (sgn) q_s.push_back(model(1'b1, a, b));
         else q_u.push_back(model(1'b0, a, b));
      end
      if (sgn) s_snk_valid = 1'b0;
      else u_snk_valid = 1'b0;
      check("accept", 64'(ok), 1);
   endtask
   task automatic cycles(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask
   initial begin
      #100000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end
   initial begin
      for (int i = 0; i < 3; i++) begin
         u_snk_valid = 1'(($urandom)); u_snk_data = 16'($urandom); u_src_ready = 1'($urandom);
         s_snk_valid = 1'(($urandom)); s_snk_data = 16'($urandom); s_src_ready = 1'($urandom);
         @(posedge clk);
         #1;
         check("rst_u_ready", u_snk_ready, 0);
         check("rst_u_valid", u_src_valid, 0);
         check("rst_u_busy", u_busy, 0);
         check("rst_u_cnt", u_cnt, 0);
         check("rst_u_data", u_src_data, 0);
         check("rst_s_ready", s_snk_ready, 0);
         check("rst_s_cnt", s_cnt, 0);
      end
      rst = 1'b0;
      u_snk_valid = 1'b0; u_src_ready = 1'b0;
      s_snk_valid = 1'b0; s_src_ready = 1'b0;
      #1;
      check("rel_u_ready", u_snk_ready, 1);
      check("rel_s_ready", s_snk_ready, 1);
      // Single unsigned op with latency/busy timing.
      u_src_ready = 1'b1;
      send(1'b0, 8'd13, 8'd11, 1'b1);
      check("t2_busy0", u_busy, 1);
      check("t2_valid0", u_src_valid, 0);
      cycles(8);
      check("t2_busy8", u_busy, 1);
      check("t2_valid8", u_src_valid, 0);
      cycles(1);
      check("t2_busy9", u_busy, 0);
      check("t2_valid9", u_src_valid, 1);
      check("t2_cnt9", u_cnt, 1);
      check("t2_data9", u_src_data, 16'h008F);
      cycles(2);
      check("t2_empty", u_cnt, 0);
      // Signed instance, including the most-negative squared.
      s_src_ready = 1'b1;
      send(1'b1, 8'h80, 8'h80, 1'b1);
      send(1'b1, 8'hFF, 8'h02, 1'b1);
      send(1'b1, 8'h7F, 8'h81, 1'b1);
      send(1'b1, 8'h00, 8'h80, 1'b1);
      send(1'b1, 8'h80, 8'h7F, 1'b1);
      cycles(15);
      check("t3_empty", s_cnt, 0);
      // Backpressure: four fill the FIFO, the fifth waits for a slot.
      u_src_ready = 1'b0;
      fork
         for (int k = 1; k <= 5; k++) send(1'b0, 8'(k), 8'(k), 1'b1);
         begin
            cycles(60);
            check("t4_cnt", u_cnt, 4);
            check("t4_ready", u_snk_ready, 0);
            check("t4_head", u_src_data, 16'd1);
            cycles(3);
            check("t4_hold", u_src_data, 16'd1);
            check("t4_valid", u_src_valid, 1);
            u_src_ready = 1'b1;
         end
      join
      cycles(15);
      check("t4_empty", u_cnt, 0);
      // Push and pop on the same edge.
      u_src_ready = 1'b0;
      send(1'b0, 8'd3, 8'd7, 1'b1);
      send(1'b0, 8'd9, 8'd9, 1'b1);
      send(1'b0, 8'd15, 8'd17, 1'b1);
      check("t5_cnt_pre", u_cnt, 2);
      cycles(8);
      check("t5_busy", u_busy, 1);
      u_src_ready = 1'b1;
      cycles(1);
      u_src_ready = 1'b0;
      check("t5_cnt_same", u_cnt, 2);
      check("t5_head", u_src_data, 16'd81);
      u_src_ready = 1'b1;
      cycles(4);
      check("t5_empty", u_cnt, 0);
      // Reset during CALC drops the op.
      send(1'b0, 8'd50, 8'd60, 1'b0);
      cycles(4);
      rst = 1'b1;
      cycles(1);
      rst = 1'b0;
      check("t6_busy", u_busy, 0);
      cycles(15);
      check("t6_cnt", u_cnt, 0);
      check("t6_valid", u_src_valid, 0);
      send(1'b0, 8'd200, 8'd200, 1'b1);
      cycles(12);
      check("t6_empty", u_cnt, 0);
      check("u_left", 64'(q_u.size()), 0);
      check("s_left", 64'(q_s.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
